stopwatch_ctrl: RTL
===================

// Module: stopwatch_ctrl
// PURPOSE
//   Front-panel controller that sequences the BCD stopwatch datapath from two raw pushbuttons.
//   Synchronises and debounces both buttons and runs a 4-state FSM (IDLE/RUN/LAP/STOP).
//   Drives the counter enable and a synchronous clear into the watch datapath.
//   Captures a lap snapshot and muxes live or frozen digits to the display.
// PARAMETERS
//   DB_CYCLES  16  consecutive stable synchronised samples required before a button level is accepted (>=2)
// PORTS
//   clk       in   1  system clock; everything is clocked on its rising edge
//   rst       in   1  asynchronous, active-low reset
//   btn_ss    in   1  raw start/stop button, active-high, asynchronous to clk
//   btn_lr    in   1  raw lap/reset button, active-high, asynchronous to clk
//   y2,y1,y0  in   4  live BCD digits from the watch datapath
//   en        out  1  count enable to the watch datapath
//   clr       out  1  one-cycle synchronous clear pulse to the watch datapath
//   d2,d1,d0  out  4  BCD digits to the display (live or lap snapshot)
//   state     out  2  FSM state: 00 IDLE, 01 RUN, 10 LAP, 11 STOP
// BEHAVIOUR
//   Reset (rst=0, asynchronous):
//     - state=IDLE, en=0, clr=0.
//     - Lap register cleared to 0.
//     - Synchronisers, debounced levels and debounce counters cleared to 0.
//     - Reset mid-operation aborts everything immediately, with no clr pulse.
//   Synchroniser and debounce, per button:
//     - 2-flop synchroniser produces level s.
//     - A counter of width $clog2(DB_CYCLES+1) tracks disagreement between s and the accepted level db.
//     - If s==db, the counter is cleared.
//     - If s!=db, the counter increments.
//     - On the DB_CYCLES-th consecutive cycle of s!=db: db<=s and the counter is cleared.
//     - Any glitch shorter than DB_CYCLES samples is ignored.
//     - Press event ev = db & ~db_q, a single-cycle pulse on the db rising edge. Release produces no event.
//   Latency:
//     - Raw button first sampled high at edge k, held stable.
//     - ev is high during the cycle following edge k+1+DB_CYCLES.
//     - state/en/clr update at edge k+2+DB_CYCLES.
//   FSM transitions (registered, evaluated on ev_ss/ev_lr):
//     - IDLE: ev_ss -> RUN; ev_lr ignored.
//     - RUN:  ev_ss -> STOP; ev_lr -> LAP, and lap register <= {y2,y1,y0} on the same edge.
//     - LAP:  ev_ss -> STOP; ev_lr -> RUN (display released to live digits).
//     - STOP: ev_ss -> RUN (resume, no clear); ev_lr -> IDLE with clr=1 for exactly one cycle.
//   Simultaneous ev_ss and ev_lr in the same cycle:
//     - ev_ss takes priority and ev_lr is discarded.
//     - In RUN, such a collision does not capture a lap.
//   Outputs:
//     - en is registered: en=1 in RUN and LAP, 0 in IDLE and STOP.
//       The watch keeps counting while a lap is displayed.
//     - clr is registered and asserted only on the STOP->IDLE edge.
//     - {d2,d1,d0} = lap register when state==LAP, else {y2,y1,y0}. This mux is combinational.
//     - The lap register holds its value until the next capture or reset. It is not cleared by clr.
//   Width rules:
//     - Digits pass through unmodified. The block performs no BCD arithmetic.
//     - Holding a button continuously produces exactly one event.
// TESTING (DB_CYCLES=4)
//   1. Reset, then btn_ss high from edge k:
//      - en=0 through edge k+5; en=1 and state=01 at edge k+6.
//   2. btn_ss pulses of 3 cycles, repeated 10 times with gaps:
//      - no event; state stays 00 and en stays 0.
//   3. In RUN with y=3,4,5, press btn_lr:
//      - state=10 and d=3,4,5 while y keeps advancing.
//      - Press btn_lr again: state=01 and d tracks y.
//   4. RUN -> btn_ss -> STOP (en=0, d unchanged); then btn_lr:
//      - state=00 and clr high for exactly 1 cycle; then btn_lr in IDLE leaves state=00.
//   5. In RUN, both buttons rise on the same edge:
//      - state=11, no lap capture (lap register keeps its old value), clr=0.
//   6. In LAP, assert rst=0 asynchronously mid-cycle:
//      - en=0 and state=00 immediately, clr never pulses.
//      - After release, one btn_ss press returns state=01.

Source files
------------

// File: rtl/stopwatch_ctrl.sv
// Front-panel controller for the BCD stopwatch: debounces two pushbuttons, runs the
// IDLE/RUN/LAP/STOP sequencer and selects live or lap-frozen digits for the display.
module stopwatch_ctrl #(
    parameter int DB_CYCLES = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_ss,
    input  logic       btn_lr,
    input  logic [3:0] y2,
    input  logic [3:0] y1,
    input  logic [3:0] y0,
    output logic       en,
    output logic       clr,
    output logic [3:0] d2,
    output logic [3:0] d1,
    output logic [3:0] d0,
    output logic [1:0] state
);

    localparam int CW = $clog2(DB_CYCLES + 1);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        LAP  = 2'b10,
        STOP = 2'b11
    } state_t;

    // Bit 0 carries start/stop, bit 1 carries lap/reset.
    logic [1:0]    btn_raw;
    logic [1:0]    sync_p0;
    logic [1:0]    sync_p1;
    logic [1:0]    db;
    logic [1:0]    db_q;
    logic [1:0]    ev;
    logic [CW-1:0] cnt [2];

    state_t        state_q;
    state_t        state_nxt;
    logic          en_nxt;
    logic          clr_nxt;
    logic          lap_ld;
    logic [11:0]   lap;

    assign btn_raw = {btn_lr, btn_ss};

    // Synchroniser and debounce stage
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_p0 <= '0;
            sync_p1 <= '0;
            db      <= '0;
            db_q    <= '0;
            cnt[0]  <= '0;
            cnt[1]  <= '0;
        end else begin
            sync_p0 <= btn_raw;
            sync_p1 <= sync_p0;
            db_q    <= db;
            for (int i = 0; i < 2; i++) begin
                if (sync_p1[i] == db[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CW'(DB_CYCLES - 1)) begin
                    db[i]  <= sync_p1[i];
                    cnt[i] <= '0;
                end else begin
                    cnt[i] <= cnt[i] + CW'(1);
                end
            end
        end
    end

    assign ev = db & ~db_q;

    // Sequencer stage: start/stop always wins a same-cycle collision
    always_comb begin
        state_nxt = state_q;
        clr_nxt   = 1'b0;
        lap_ld    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (ev[0]) state_nxt = RUN;
            end
            RUN: begin
                if (ev[0]) begin
                    state_nxt = STOP;
                end else if (ev[1]) begin
                    state_nxt = LAP;
                    lap_ld    = 1'b1;
                end
            end
            LAP: begin
                if (ev[0])      state_nxt = STOP;
                else if (ev[1]) state_nxt = RUN;
            end
            STOP: begin
                if (ev[0]) begin
                    state_nxt = RUN;
                end else if (ev[1]) begin
                    state_nxt = IDLE;
                    clr_nxt   = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
        en_nxt = (state_nxt == RUN) || (state_nxt == LAP);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            en      <= 1'b0;
            clr     <= 1'b0;
            lap     <= '0;
        end else begin
            state_q <= state_nxt;
            en      <= en_nxt;
            clr     <= clr_nxt;
            if (lap_ld) lap <= {y2, y1, y0};
        end
    end

    // Display select stage
    assign state        = state_q;
    assign {d2, d1, d0} = (state_q == LAP) ? lap : {y2, y1, y0};

endmodule
